// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the mips32 pipeline.
// Holds the EX/MEM register, runs the req/ack data-memory handshake for
// Lw/Sw, stalls the front of the pipe while an access is outstanding and
// produces the MEM/WB register consumed by WB and the forwarding unit.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        Clock,
    input  logic        Reset,
    // EX stage results
    input  logic        EX_Valid,
    input  logic [31:0] EX_ALUOut,
    input  logic [31:0] EX_StoreData,
    input  logic [4:0]  EX_RegRd,
    input  logic        EX_RegWrite,
    input  logic        EX_MemToReg,
    input  logic        EX_MemRead,
    input  logic        EX_MemWrite,
    // pipeline freeze
    output logic        MemStall,
    // data-memory port
    output logic        DMem_Req,
    output logic        DMem_We,
    output logic [31:0] DMem_Addr,
    output logic [31:0] DMem_WData,
    input  logic        DMem_Ack,
    input  logic [31:0] DMem_RData,
    // EX/MEM fields
    output logic [4:0]  EXMEM_RegRd,
    output logic        EXMEM_RegWrite,
    output logic        EXMEM_MemWrite,
    output logic [31:0] EXMEM_ALUOut,
    // MEM/WB fields
    output logic [4:0]  MEMWB_RegRd,
    output logic        MEMWB_RegWrite,
    output logic        MEMWB_MemToReg,
    output logic [31:0] MEMWB_ALUOut,
    output logic [31:0] MEMWB_MemData,
    // error pulses
    output logic        AddrErr,
    output logic        BusErr
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } stateT;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    stateT       state;
    stateT       stateNext;
    logic [7:0]  waitCount;

    logic        exmemMemRead;
    logic        exmemMemToReg;

    logic        loadEn;
    logic        exMemOp;
    logic        exAligned;
    logic        enterAccess;
    logic        exmemMemOp;
    logic        exmemAligned;
    logic        timeoutHit;
    logic        accessDone;

    // Decode of the incoming EX slot and of the op currently in EX/MEM
    always_comb begin
        exMemOp      = EX_Valid & (EX_MemRead | EX_MemWrite);
        exAligned    = (EX_ALUOut[1:0] == 2'b00);
        exmemMemOp   = exmemMemRead | EXMEM_MemWrite;
        exmemAligned = (EXMEM_ALUOut[1:0] == 2'b00);
        timeoutHit   = (state == ACCESS) & (waitCount == TIMEOUT_LAST) & ~DMem_Ack;
        accessDone   = (state == ACCESS) & DMem_Ack;
        MemStall     = (state == ACCESS) & ~DMem_Ack & ~timeoutHit;
        loadEn       = ~MemStall;
        enterAccess  = loadEn & exMemOp & exAligned;
        AddrErr      = exmemMemOp & ~exmemAligned;
        BusErr       = timeoutHit;
    end

    // Next-state: a stalled access stays put; otherwise the state follows
    // whatever is loaded into EX/MEM on this edge, so a completing access
    // chains straight into the next aligned Lw/Sw without an IDLE gap.
    always_comb begin
        stateNext = state;
        if (MemStall) begin
            stateNext = ACCESS;
        end else if (enterAccess) begin
            stateNext = ACCESS;
        end else begin
            stateNext = IDLE;
        end
    end

    // State register and registered memory request
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            DMem_Req <= 1'b0;
        end else begin
            state    <= stateNext;
            DMem_Req <= (stateNext == ACCESS);
        end
    end

    // Wait-cycle counter for the bus timeout
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            waitCount <= '0;
        end else if (enterAccess) begin
            waitCount <= '0;
        end else if ((state == ACCESS) && !DMem_Ack) begin
            waitCount <= waitCount + 8'd1;
        end
    end

    // EX/MEM register: loads whenever the pipe is not stalled
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            EXMEM_ALUOut   <= '0;
            DMem_WData     <= '0;
            EXMEM_RegRd    <= '0;
            EXMEM_RegWrite <= 1'b0;
            EXMEM_MemWrite <= 1'b0;
            exmemMemRead   <= 1'b0;
            exmemMemToReg  <= 1'b0;
        end else if (loadEn) begin
            EXMEM_ALUOut   <= EX_ALUOut;
            DMem_WData     <= EX_StoreData;
            EXMEM_RegRd    <= EX_Valid ? EX_RegRd : 5'd0;
            EXMEM_RegWrite <= EX_Valid & EX_RegWrite;
            EXMEM_MemWrite <= EX_Valid & EX_MemWrite;
            exmemMemRead   <= EX_Valid & EX_MemRead;
            exmemMemToReg  <= EX_Valid & EX_MemToReg;
        end
    end

    // Address and direction come straight from the EX/MEM register, so they
    // stay stable for as long as the request is held.
    always_comb begin
        DMem_Addr = EXMEM_ALUOut;
        DMem_We   = EXMEM_MemWrite;
    end

    // MEM/WB register: completed accesses and non-memory ops pass through;
    // stall, timeout and misaligned cycles insert a bubble.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            MEMWB_RegRd    <= '0;
            MEMWB_RegWrite <= 1'b0;
            MEMWB_MemToReg <= 1'b0;
            MEMWB_ALUOut   <= '0;
            MEMWB_MemData  <= '0;
        end else if (accessDone) begin
            MEMWB_RegRd    <= EXMEM_RegRd;
            MEMWB_RegWrite <= EXMEM_RegWrite & ~EXMEM_MemWrite;
            MEMWB_MemToReg <= exmemMemToReg;
            MEMWB_ALUOut   <= EXMEM_ALUOut;
            if (exmemMemRead) begin
                MEMWB_MemData <= DMem_RData;
            end
        end else if ((state == ACCESS) || (exmemMemOp && !exmemAligned)) begin
            MEMWB_RegWrite <= 1'b0;
            MEMWB_MemToReg <= 1'b0;
        end else begin
            MEMWB_RegRd    <= EXMEM_RegRd;
            MEMWB_RegWrite <= EXMEM_RegWrite;
            MEMWB_MemToReg <= EXMEM_MemToReg_passthrough(exmemMemToReg);
            MEMWB_ALUOut   <= EXMEM_ALUOut;
        end
    end

    function automatic logic EXMEM_MemToReg_passthrough(input logic m2r);
        return m2r;
    endfunction

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed tests for the MEM pipeline stage.
module tb_mem_access_stage;

    logic        Clock;
    logic        Reset;
    logic        EX_Valid;
    logic [31:0] EX_ALUOut;
    logic [31:0] EX_StoreData;
    logic [4:0]  EX_RegRd;
    logic        EX_RegWrite;
    logic        EX_MemToReg;
    logic        EX_MemRead;
    logic        EX_MemWrite;
    logic        MemStall;
    logic        DMem_Req;
    logic        DMem_We;
    logic [31:0] DMem_Addr;
    logic [31:0] DMem_WData;
    logic        DMem_Ack;
    logic [31:0] DMem_RData;
    logic [4:0]  EXMEM_RegRd;
    logic        EXMEM_RegWrite;
    logic        EXMEM_MemWrite;
    logic [31:0] EXMEM_ALUOut;
    logic [4:0]  MEMWB_RegRd;
    logic        MEMWB_RegWrite;
    logic        MEMWB_MemToReg;
    logic [31:0] MEMWB_ALUOut;
    logic [31:0] MEMWB_MemData;
    logic        AddrErr;
    logic        BusErr;

    int passCount  = 0;
    int checkCount = 0;

    mem_access_stage #(.TIMEOUT(4)) dut (
        .Clock(Clock), .Reset(Reset),
        .EX_Valid(EX_Valid), .EX_ALUOut(EX_ALUOut), .EX_StoreData(EX_StoreData),
        .EX_RegRd(EX_RegRd), .EX_RegWrite(EX_RegWrite), .EX_MemToReg(EX_MemToReg),
        .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
        .MemStall(MemStall),
        .DMem_Req(DMem_Req), .DMem_We(DMem_We), .DMem_Addr(DMem_Addr),
        .DMem_WData(DMem_WData), .DMem_Ack(DMem_Ack), .DMem_RData(DMem_RData),
        .EXMEM_RegRd(EXMEM_RegRd), .EXMEM_RegWrite(EXMEM_RegWrite),
        .EXMEM_MemWrite(EXMEM_MemWrite), .EXMEM_ALUOut(EXMEM_ALUOut),
        .MEMWB_RegRd(MEMWB_RegRd), .MEMWB_RegWrite(MEMWB_RegWrite),
        .MEMWB_MemToReg(MEMWB_MemToReg), .MEMWB_ALUOut(MEMWB_ALUOut),
        .MEMWB_MemData(MEMWB_MemData),
        .AddrErr(AddrErr), .BusErr(BusErr)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Hard stop in case the sequence ever stalls
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic driveEx(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                           input logic [4:0] rd, input logic rw, input logic m2r,
                           input logic mr, input logic mw);
        EX_Valid = v; EX_ALUOut = alu; EX_StoreData = sd; EX_RegRd = rd;
        EX_RegWrite = rw; EX_MemToReg = m2r; EX_MemRead = mr; EX_MemWrite = mw;
    endtask

    task automatic bubble();
        driveEx(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        Reset = 1'b0; DMem_Ack = 1'b0; DMem_RData = '0;
        bubble();
        step(); step();
        checkCount++; if (DMem_Req !== 1'b0) $display("FAIL rst_req got %0h exp 0", DMem_Req); else passCount++;
        checkCount++; if (MemStall !== 1'b0) $display("FAIL rst_stall got %0h exp 0", MemStall); else passCount++;
        checkCount++; if (MEMWB_ALUOut !== 32'h0) $display("FAIL rst_memwb_alu got %h exp 0", MEMWB_ALUOut); else passCount++;
        checkCount++; if (EXMEM_ALUOut !== 32'h0) $display("FAIL rst_exmem_alu got %h exp 0", EXMEM_ALUOut); else passCount++;
        Reset = 1'b1;
        step();
    endtask

    task automatic test_alu_pass();
        driveEx(1'b1, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        bubble();
        #1;
        checkCount++; if (DMem_Req !== 1'b0) $display("FAIL alu_req got %0h exp 0", DMem_Req); else passCount++;
        checkCount++; if (MemStall !== 1'b0) $display("FAIL alu_stall got %0h exp 0", MemStall); else passCount++;
        checkCount++; if (EXMEM_ALUOut !== 32'h1234) $display("FAIL alu_exmem got %h exp 00001234", EXMEM_ALUOut); else passCount++;
        step();
        checkCount++; if (MEMWB_ALUOut !== 32'h1234) $display("FAIL alu_memwb got %h exp 00001234", MEMWB_ALUOut); else passCount++;
        checkCount++; if (MEMWB_RegRd !== 5'd5) $display("FAIL alu_rd got %0d exp 5", MEMWB_RegRd); else passCount++;
        checkCount++; if (MEMWB_RegWrite !== 1'b1) $display("FAIL alu_rw got %0h exp 1", MEMWB_RegWrite); else passCount++;
    endtask

    task automatic test_load_wait();
        driveEx(1'b1, 32'h100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        // next instruction waits in EX while the load is stalled
        driveEx(1'b1, 32'h55, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkCount++; if (MemStall !== 1'b1) $display("FAIL lw_stall%0d got %0h exp 1", i, MemStall); else passCount++;
            checkCount++; if (DMem_Req !== 1'b1 || DMem_Addr !== 32'h100 || DMem_We !== 1'b0)
                $display("FAIL lw_req%0d got req=%0h addr=%h we=%0h exp req=1 addr=00000100 we=0", i, DMem_Req, DMem_Addr, DMem_We);
            else passCount++;
            step();
            checkCount++; if (MEMWB_RegWrite !== 1'b0) $display("FAIL lw_bubble%0d got %0h exp 0", i, MEMWB_RegWrite); else passCount++;
        end
        DMem_Ack = 1'b1; DMem_RData = 32'hDEADBEEF;
        #1;
        checkCount++; if (MemStall !== 1'b0) $display("FAIL lw_ack_stall got %0h exp 0", MemStall); else passCount++;
        checkCount++; if (BusErr !== 1'b0) $display("FAIL lw_ack_wins got %0h exp 0", BusErr); else passCount++;
        step();
        DMem_Ack = 1'b0; DMem_RData = '0;
        bubble();
        checkCount++; if (MEMWB_MemData !== 32'hDEADBEEF) $display("FAIL lw_data got %h exp deadbeef", MEMWB_MemData); else passCount++;
        checkCount++; if (MEMWB_MemToReg !== 1'b1 || MEMWB_RegWrite !== 1'b1 || MEMWB_RegRd !== 5'd7)
            $display("FAIL lw_ctrl got m2r=%0h rw=%0h rd=%0d exp m2r=1 rw=1 rd=7", MEMWB_MemToReg, MEMWB_RegWrite, MEMWB_RegRd);
        else passCount++;
        checkCount++; if (DMem_Req !== 1'b0) $display("FAIL lw_req_drop got %0h exp 0", DMem_Req); else passCount++;
        checkCount++; if (EXMEM_ALUOut !== 32'h55) $display("FAIL lw_held_ex got %h exp 00000055", EXMEM_ALUOut); else passCount++;
        step();
        checkCount++; if (MEMWB_ALUOut !== 32'h55 || MEMWB_RegRd !== 5'd9)
            $display("FAIL lw_next got alu=%h rd=%0d exp alu=00000055 rd=9", MEMWB_ALUOut, MEMWB_RegRd);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        DMem_Ack = 1'b1;
        driveEx(1'b1, 32'h200, 32'hA5A5A5A5, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        driveEx(1'b1, 32'h204, 32'h0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        DMem_RData = 32'h11112222;
        #1;
        checkCount++; if (DMem_Req !== 1'b1 || DMem_Addr !== 32'h200 || DMem_We !== 1'b1 || DMem_WData !== 32'hA5A5A5A5)
            $display("FAIL b2b_sw got req=%0h addr=%h we=%0h wd=%h exp 1 00000200 1 a5a5a5a5", DMem_Req, DMem_Addr, DMem_We, DMem_WData);
        else passCount++;
        checkCount++; if (MemStall !== 1'b0) $display("FAIL b2b_stall0 got %0h exp 0", MemStall); else passCount++;
        step();
        bubble();
        #1;
        checkCount++; if (DMem_Req !== 1'b1 || DMem_Addr !== 32'h204 || DMem_We !== 1'b0)
            $display("FAIL b2b_lw got req=%0h addr=%h we=%0h exp 1 00000204 0", DMem_Req, DMem_Addr, DMem_We);
        else passCount++;
        checkCount++; if (MEMWB_RegWrite !== 1'b0) $display("FAIL b2b_sw_rw got %0h exp 0", MEMWB_RegWrite); else passCount++;
        checkCount++; if (MemStall !== 1'b0) $display("FAIL b2b_stall1 got %0h exp 0", MemStall); else passCount++;
        step();
        checkCount++; if (DMem_Req !== 1'b0) $display("FAIL b2b_req_drop got %0h exp 0", DMem_Req); else passCount++;
        checkCount++; if (MEMWB_MemData !== 32'h11112222 || MEMWB_RegWrite !== 1'b1 || MEMWB_RegRd !== 5'd3)
            $display("FAIL b2b_lw_wb got data=%h rw=%0h rd=%0d exp 11112222 1 3", MEMWB_MemData, MEMWB_RegWrite, MEMWB_RegRd);
        else passCount++;
        // stray Ack with no request must not disturb anything
        #1;
        checkCount++; if (MemStall !== 1'b0) $display("FAIL b2b_stray_ack got %0h exp 0", MemStall); else passCount++;
        DMem_Ack = 1'b0; DMem_RData = '0;
        step();
    endtask

    task automatic test_misaligned();
        driveEx(1'b1, 32'h102, 32'h0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        driveEx(1'b1, 32'h77, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checkCount++; if (AddrErr !== 1'b1) $display("FAIL mis_addrerr got %0h exp 1", AddrErr); else passCount++;
        checkCount++; if (DMem_Req !== 1'b0 || MemStall !== 1'b0)
            $display("FAIL mis_noreq got req=%0h stall=%0h exp 0 0", DMem_Req, MemStall);
        else passCount++;
        step();
        bubble();
        checkCount++; if (AddrErr !== 1'b0) $display("FAIL mis_pulse got %0h exp 0", AddrErr); else passCount++;
        checkCount++; if (MEMWB_RegWrite !== 1'b0) $display("FAIL mis_bubble got %0h exp 0", MEMWB_RegWrite); else passCount++;
        step();
        checkCount++; if (MEMWB_RegWrite !== 1'b1 || MEMWB_RegRd !== 5'd6 || MEMWB_ALUOut !== 32'h77)
            $display("FAIL mis_next got rw=%0h rd=%0d alu=%h exp 1 6 00000077", MEMWB_RegWrite, MEMWB_RegRd, MEMWB_ALUOut);
        else passCount++;
    endtask

    task automatic test_timeout();
        driveEx(1'b1, 32'h300, 32'h12345678, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        bubble();
        for (int i = 0; i < 4; i++) begin
            #1;
            checkCount++; if (DMem_Req !== 1'b1) $display("FAIL to_req%0d got %0h exp 1", i, DMem_Req); else passCount++;
            checkCount++; if (BusErr !== (i == 3)) $display("FAIL to_buserr%0d got %0h exp %0h", i, BusErr, (i == 3)); else passCount++;
            checkCount++; if (MemStall !== (i != 3)) $display("FAIL to_stall%0d got %0h exp %0h", i, MemStall, (i != 3)); else passCount++;
            step();
        end
        checkCount++; if (DMem_Req !== 1'b0 || BusErr !== 1'b0 || MemStall !== 1'b0)
            $display("FAIL to_release got req=%0h bus=%0h stall=%0h exp 0 0 0", DMem_Req, BusErr, MemStall);
        else passCount++;
        checkCount++; if (MEMWB_RegWrite !== 1'b0) $display("FAIL to_bubble got %0h exp 0", MEMWB_RegWrite); else passCount++;
    endtask

    task automatic test_reset_mid();
        driveEx(1'b1, 32'h400, 32'h0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        bubble();
        #1;
        checkCount++; if (DMem_Req !== 1'b1 || MemStall !== 1'b1)
            $display("FAIL rm_pre got req=%0h stall=%0h exp 1 1", DMem_Req, MemStall);
        else passCount++;
        #1;
        Reset = 1'b0;
        #1;
        checkCount++; if (DMem_Req !== 1'b0 || MemStall !== 1'b0)
            $display("FAIL rm_async got req=%0h stall=%0h exp 0 0", DMem_Req, MemStall);
        else passCount++;
        checkCount++; if (EXMEM_ALUOut !== 32'h0 || EXMEM_RegRd !== 5'd0 || EXMEM_RegWrite !== 1'b0 || EXMEM_MemWrite !== 1'b0)
            $display("FAIL rm_exmem got alu=%h rd=%0d rw=%0h mw=%0h exp all 0", EXMEM_ALUOut, EXMEM_RegRd, EXMEM_RegWrite, EXMEM_MemWrite);
        else passCount++;
        checkCount++; if (MEMWB_ALUOut !== 32'h0 || MEMWB_MemData !== 32'h0 || MEMWB_RegRd !== 5'd0 ||
                          MEMWB_RegWrite !== 1'b0 || MEMWB_MemToReg !== 1'b0)
            $display("FAIL rm_memwb got alu=%h data=%h rd=%0d rw=%0h m2r=%0h exp all 0",
                     MEMWB_ALUOut, MEMWB_MemData, MEMWB_RegRd, MEMWB_RegWrite, MEMWB_MemToReg);
        else passCount++;
        step();
        Reset = 1'b1;
        step();
        checkCount++; if (DMem_Req !== 1'b0) $display("FAIL rm_after got %0h exp 0", DMem_Req); else passCount++;
    endtask

    initial begin
        test_reset();
        test_alu_pass();
        test_load_wait();
        test_back_to_back();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
